// File: rtl/conn_link_rx.sv
// conn_link_rx -- receive side of the byte-wide strobed backplane link.
//
// Collects framed bytes from the connector into 32-bit words (first byte is
// the MSB), optionally checks a trailing XOR parity byte, and queues good
// words in a show-ahead FIFO for local logic. Flow control goes back to the
// sender on link_busy. Errors are reported as one-cycle pulses, a sticky
// overflow flag and a saturating error counter.
//
// Build option:
//   CONN_LINK_PARITY_EN  defined   : 5-byte frames (4 data + XOR parity byte),
//                                    parity checked, par_err active.
//                        undefined : 4-byte frames, word pushed on byte 0,
//                                    par_err tied to 0.
//
// Parameters:
//   DEPTH  FIFO depth in words (power of 2, at least 2)
//   ERRW   width of the saturating error counter
//
// Ports:
//   clk        backplane clock, rising edge
//   reset      asynchronous active-high reset
//   link_data  link byte from the connector
//   link_stb   byte valid this cycle
//   link_frm   first byte of a frame (qualified by link_stb)
//   link_busy  registered flow control: 1 when at most one entry is free
//   out_data   head-of-FIFO word (0 while out_valid=0)
//   out_valid  FIFO non-empty
//   out_read   pop the head word when out_valid=1
//   par_err    one-cycle pulse: frame failed its parity check
//   frm_err    one-cycle pulse: framing violation
//   ovf        sticky: a good word was dropped because the FIFO was full
//   err_cnt    saturating count of parity, framing and drop events
//   err_clr    synchronous clear of err_cnt and ovf (wins over an increment)

module conn_link_rx #(
  parameter int DEPTH = 4,
  parameter int ERRW  = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      link_data,
  input  logic            link_stb,
  input  logic            link_frm,
  output logic            link_busy,
  output logic [31:0]     out_data,
  output logic            out_valid,
  input  logic            out_read,
  output logic            par_err,
  output logic            frm_err,
  output logic            ovf,
  output logic [ERRW-1:0] err_cnt,
  input  logic            err_clr
);

  localparam int AW = $clog2(DEPTH);

  typedef logic [AW:0] fcnt_t;

  localparam fcnt_t DEPTH_C = fcnt_t'(DEPTH);
  localparam fcnt_t BUSY_AT = fcnt_t'(DEPTH - 1);

`ifdef CONN_LINK_PARITY_EN
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAR} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_DATA} state_t;
`endif

  // ---------------------------------------------------------------------
  // Frame assembly
  // ---------------------------------------------------------------------
  state_t      state, state_nx;
  logic [2:0]  bcnt, bcnt_nx;     // data bytes captured in the current frame
  logic [31:0] word, word_nx;     // bytes shift in from the LSB end
`ifdef CONN_LINK_PARITY_EN
  logic [7:0]  acc, acc_nx;       // running XOR of the data bytes
`endif

  logic        push_req;
  logic [31:0] push_data;
  logic        par_evt;
  logic        frm_evt;

  // NOTE: every output of this block gets a default before any branch, so
  // no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_nx  = state;
    bcnt_nx   = bcnt;
    word_nx   = word;
`ifdef CONN_LINK_PARITY_EN
    acc_nx    = acc;
`endif
    push_req  = 1'b0;
    push_data = word;
    par_evt   = 1'b0;
    frm_evt   = 1'b0;

    if (link_stb) begin
      if (link_frm) begin
        // A frame start anywhere but IDLE abandons the partial word; the
        // byte itself is always taken as the new MSB.
        frm_evt  = (state != S_IDLE);
        state_nx = S_DATA;
        bcnt_nx  = 3'd1;
        word_nx  = {24'h0, link_data};
`ifdef CONN_LINK_PARITY_EN
        acc_nx   = link_data;
`endif
      end else begin
        case (state)
          S_IDLE: begin
            // Data byte with no frame start: discarded.
            frm_evt = 1'b1;
          end
          S_DATA: begin
            word_nx = {word[23:0], link_data};
            bcnt_nx = bcnt + 3'd1;
`ifdef CONN_LINK_PARITY_EN
            acc_nx  = acc ^ link_data;
            if (bcnt == 3'd3) begin
              state_nx = S_PAR;
            end
`else
            if (bcnt == 3'd3) begin
              push_req  = 1'b1;
              push_data = {word[23:0], link_data};
              state_nx  = S_IDLE;
              bcnt_nx   = 3'd0;
            end
`endif
          end
`ifdef CONN_LINK_PARITY_EN
          S_PAR: begin
            state_nx = S_IDLE;
            bcnt_nx  = 3'd0;
            if (link_data == acc) begin
              push_req = 1'b1;
            end else begin
              par_evt = 1'b1;
            end
          end
`endif
          default: begin
            state_nx = S_IDLE;
            bcnt_nx  = 3'd0;
          end
        endcase
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; the async reset sits in the sensitivity list.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      bcnt  <= 3'd0;
      word  <= 32'h0;
`ifdef CONN_LINK_PARITY_EN
      acc   <= 8'h0;
`endif
    end else begin
      state <= state_nx;
      bcnt  <= bcnt_nx;
      word  <= word_nx;
`ifdef CONN_LINK_PARITY_EN
      acc   <= acc_nx;
`endif
    end
  end

  // ---------------------------------------------------------------------
  // Show-ahead FIFO
  // ---------------------------------------------------------------------
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;   // DEPTH is a power of 2: pointers wrap
  fcnt_t         fcnt, fcnt_nx;
  logic          pop, full, push_ok, drop;

  assign out_valid = (fcnt != '0);
  assign full      = (fcnt == DEPTH_C);
  // A pop when empty is ignored, which also covers push+pop on an empty FIFO.
  assign pop       = out_read & out_valid;
  // A full FIFO still accepts a word if the head leaves on the same edge.
  assign push_ok   = push_req & (~full | pop);
  assign drop      = push_req & full & ~pop;
  assign out_data  = out_valid ? mem[rd_ptr] : 32'h0;

  always_comb begin
    case ({push_ok, pop})
      2'b10:   fcnt_nx = fcnt + fcnt_t'(1);
      2'b01:   fcnt_nx = fcnt - fcnt_t'(1);
      default: fcnt_nx = fcnt;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      fcnt      <= '0;
      link_busy <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      fcnt      <= fcnt_nx;
      // Busy once no more than one entry will be free after this edge.
      link_busy <= (fcnt_nx >= BUSY_AT);
    end
  end

  // NOTE: the storage array has no reset; emptiness is tracked by fcnt and
  // out_data is masked while the FIFO is empty, so stale words never show.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // ---------------------------------------------------------------------
  // Error reporting
  // ---------------------------------------------------------------------
  logic err_evt;

  // The frame logic cannot flag a framing error and push on the same byte,
  // so at most one of these is set in any cycle.
  assign err_evt = par_evt | frm_evt | drop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_err <= 1'b0;
      frm_err <= 1'b0;
      ovf     <= 1'b0;
      err_cnt <= '0;
    end else begin
      par_err <= par_evt;
      frm_err <= frm_evt;
      if (err_clr) begin
        ovf     <= 1'b0;
        err_cnt <= '0;
      end else begin
        if (drop) ovf <= 1'b1;
        if (err_evt && (err_cnt != '1)) err_cnt <= err_cnt + ERRW'(1);
      end
    end
  end

endmodule

// File: tb/tb_conn_link_rx.sv
// Testbench for conn_link_rx. Works with or without CONN_LINK_PARITY_EN.
// A frame-level reference model (byte queue per frame, word queue for the
// FIFO) predicts every output; a single monitor compares on the falling edge.

module tb_conn_link_rx;

  localparam int DEPTH = 4;
  localparam int ERRW  = 8;
`ifdef CONN_LINK_PARITY_EN
  localparam int FLEN  = 5;
`else
  localparam int FLEN  = 4;
`endif

  logic            clk;
  logic            reset;
  logic [7:0]      link_data;
  logic            link_stb;
  logic            link_frm;
  logic            link_busy;
  logic [31:0]     out_data;
  logic            out_valid;
  logic            out_read;
  logic            par_err;
  logic            frm_err;
  logic            ovf;
  logic [ERRW-1:0] err_cnt;
  logic            err_clr;

  conn_link_rx #(.DEPTH(DEPTH), .ERRW(ERRW)) dut (
    .clk       (clk),
    .reset     (reset),
    .link_data (link_data),
    .link_stb  (link_stb),
    .link_frm  (link_frm),
    .link_busy (link_busy),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_read  (out_read),
    .par_err   (par_err),
    .frm_err   (frm_err),
    .ovf       (ovf),
    .err_cnt   (err_cnt),
    .err_clr   (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int rd_mode  = 0;  // 0: no reads, 1: always read, 2: random, 3: manual

  // ---------------- reference model state ----------------
  logic [31:0]     exp_q[$];   // words expected in the FIFO, head first
  logic [7:0]      fr[$];      // bytes of the frame being received
  logic [ERRW-1:0] m_cnt  = '0;
  bit              m_ovf  = 1'b0;
  bit              m_par  = 1'b0;
  bit              m_frm  = 1'b0;
  bit              m_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one clock edge of frame-level rules to the model.
  task automatic model_step();
    int          ev;
    bit          push;
    logic [31:0] w;
    ev    = 0;
    push  = 1'b0;
    w     = 32'h0;
    m_par = 1'b0;
    m_frm = 1'b0;
    if (link_stb) begin
      if (link_frm) begin
        if (fr.size() > 0) begin
          m_frm = 1'b1;
          ev++;
        end
        fr.delete();
        fr.push_back(link_data);
      end else if (fr.size() == 0) begin
        m_frm = 1'b1;
        ev++;
      end else begin
        fr.push_back(link_data);
        if (fr.size() == FLEN) begin
          w    = {fr[0], fr[1], fr[2], fr[3]};
          push = 1'b1;
`ifdef CONN_LINK_PARITY_EN
          if (fr[4] != (fr[0] ^ fr[1] ^ fr[2] ^ fr[3])) begin
            push  = 1'b0;
            m_par = 1'b1;
            ev++;
          end
`endif
          fr.delete();
        end
      end
    end
    // exp_q already reflects a pop happening on this same edge.
    if (push) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(w);
      else begin
        m_ovf = 1'b1;
        ev++;
      end
    end
    if (err_clr) begin
      m_cnt = '0;
      m_ovf = 1'b0;
    end else begin
      repeat (ev) if (m_cnt != {ERRW{1'b1}}) m_cnt = m_cnt + 1'b1;
    end
    m_busy = ((DEPTH - exp_q.size()) <= 1);
  endtask

  // Monitor on the falling edge, model update on the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data",  out_data,  0);
        check("rst_link_busy", link_busy, 0);
        check("rst_par_err",   par_err,   0);
        check("rst_frm_err",   frm_err,   0);
        check("rst_ovf",       ovf,       0);
        check("rst_err_cnt",   err_cnt,   0);
      end else begin
        check("out_valid", out_valid, exp_q.size() > 0);
        if (exp_q.size() > 0) check("out_data", out_data, exp_q[0]);
        else                  check("out_data_empty", out_data, 0);
        check("par_err",   par_err,   m_par);
        check("frm_err",   frm_err,   m_frm);
        check("ovf",       ovf,       m_ovf);
        check("err_cnt",   err_cnt,   m_cnt);
        check("link_busy", link_busy, m_busy);
        if (out_read && exp_q.size() > 0) void'(exp_q.pop_front());
      end
      @(posedge clk);
      if (reset) begin
        exp_q.delete();
        fr.delete();
        m_cnt  = '0;
        m_ovf  = 1'b0;
        m_par  = 1'b0;
        m_frm  = 1'b0;
        m_busy = 1'b0;
      end else begin
        model_step();
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    case (rd_mode)
      0:       out_read = 1'b0;
      1:       out_read = 1'b1;
      2:       out_read = 1'($urandom_range(0, 1));
      default: ;
    endcase
    err_clr = (rd_mode == 2) && ($urandom_range(0, 63) == 0);
  endtask

  task automatic drive(input logic s, input logic f, input logic [7:0] d);
    link_stb  = s;
    link_frm  = f;
    link_data = d;
    tick();
    link_stb  = 1'b0;
    link_frm  = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] w, input bit bad_par, input int gap_max,
                            input bit pop_last);
    logic [7:0] b[5];
    b[0] = w[31:24];
    b[1] = w[23:16];
    b[2] = w[15:8];
    b[3] = w[7:0];
    b[4] = (b[0] ^ b[1] ^ b[2] ^ b[3]) ^ {7'h0, bad_par};
    for (int i = 0; i < FLEN; i++) begin
      repeat ($urandom_range(0, gap_max)) tick();
      if (pop_last && i == FLEN - 1) out_read = 1'b1;
      drive(1'b1, i == 0, b[i]);
      if (pop_last && i == FLEN - 1) out_read = 1'b0;
    end
  endtask

  task automatic drain();
    rd_mode = 1;
    repeat (DEPTH + 3) tick();
    rd_mode = 0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    link_data = 8'h0;
    link_stb  = 1'b0;
    link_frm  = 1'b0;
    out_read  = 1'b0;
    err_clr   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // 1: good frame DEADBEEF, contiguous strobes.
    send_frame(32'hDEADBEEF, 1'b0, 0, 1'b0);
    repeat (2) tick();
    drain();

    // 2: same frame with a corrupted parity byte (parity builds only).
`ifdef CONN_LINK_PARITY_EN
    send_frame(32'hDEADBEEF, 1'b1, 0, 1'b0);
    repeat (2) tick();
`endif

    // 3: frame start after two bytes, then a full good frame.
    drive(1'b1, 1'b1, 8'hDE);
    drive(1'b1, 1'b0, 8'hAD);
    send_frame(32'h01020304, 1'b0, 0, 1'b0);
    repeat (2) tick();
    drain();

    // 4: fill the FIFO without reads, overflow once, then push+pop while full.
    for (int i = 0; i < 5; i++) send_frame(32'h1000_0000 + i, 1'b0, 1, 1'b0);
    rd_mode = 3;
    send_frame(32'h2000_0006, 1'b0, 0, 1'b1);
    repeat (2) tick();
    drain();

    // 5: saturate the error counter, then clear together with an error.
    for (int i = 0; i < 300; i++) drive(1'b1, 1'b0, 8'($urandom));
    tick();
    err_clr = 1'b1;
    drive(1'b1, 1'b0, 8'h55);
    repeat (2) tick();

    // 6: reset in the middle of a frame with words queued.
    send_frame(32'hCAFEBABE, 1'b0, 0, 1'b0);
    send_frame(32'h0BADF00D, 1'b0, 0, 1'b0);
    drive(1'b1, 1'b1, 8'h12);
    drive(1'b1, 1'b0, 8'h34);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    send_frame(32'hCAFEBABE, 1'b0, 0, 1'b0);
    repeat (2) tick();
    drain();

    // Randomized traffic with random reads and occasional clears.
    rd_mode = 2;
    for (int f = 0; f < 400; f++) begin
      int k;
      k = $urandom_range(0, 9);
      if ($urandom_range(0, 3) != 0) begin
        int n = 0;
        while (link_busy && n < 30) begin
          tick();
          n++;
        end
      end
      if (k == 0) begin
        drive(1'b1, 1'b0, 8'($urandom));
      end else if (k == 1) begin
        int nb;
        nb = $urandom_range(1, FLEN - 1);
        for (int i = 0; i < nb; i++) drive(1'b1, i == 0, 8'($urandom));
      end else begin
        send_frame($urandom, (k == 2), 2, 1'b0);
      end
    end

    rd_mode = 1;
    repeat (DEPTH + 6) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conn_link_rx.md
Name: conn_link_rx

Overview:
- Receiving end of the byte-wide strobed card-to-card link carried on the 90-pin backplane connector.
- The sending card drives LINK_DATA/LINK_STB/LINK_FRM across the connector, synchronous to the shared backplane CLK.
- This block assembles framed bytes into 32-bit words, checks frame parity, and buffers words in a small FIFO for local logic.
- It returns flow control to the sender on LINK_BUSY and reports errors.

Parameters:
- DEPTH, 4, FIFO depth in words (power of 2, min 2).
- ERRW, 8, width of the saturating error counter.

Ports:
- CLK  input  1  backplane clock; all logic on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- LINK_DATA  input  8  link byte from the connector.
- LINK_STB  input  1  byte valid this cycle.
- LINK_FRM  input  1  first byte of frame; qualified by LINK_STB.
- LINK_BUSY  output  1  flow control to the sender.
- OUT_DATA  output  32  head-of-FIFO word.
- OUT_VALID  output  1  FIFO non-empty.
- OUT_READ  input  1  pop head word when OUT_VALID=1.
- PAR_ERR  output  1  one-cycle pulse on a parity-failed frame.
- FRM_ERR  output  1  one-cycle pulse on a framing violation.
- OVF  output  1  sticky: a good word was dropped because the FIFO was full.
- ERR_CNT  output  ERRW  saturating count of PAR_ERR + FRM_ERR + drop events.
- ERR_CLR  input  1  synchronous clear of ERR_CNT and OVF.

Behaviour:
- Reset (async): state IDLE, byte count 0, FIFO empty. All outputs 0, except OUT_DATA, which is don't-care while OUT_VALID=0 and is driven 0.
- Frame format: FRM byte = data byte 3 (MSB), then bytes 2, 1, 0, then one parity byte. The parity byte equals the XOR of the four data bytes.
- Idle cycles (STB=0) are allowed anywhere inside a frame and do not change state.

State machine:
- IDLE:
  - STB&FRM → capture byte 3, go to DATA with count=1.
  - STB&!FRM → discard the byte, pulse FRM_ERR, stay in IDLE.
- DATA:
  - STB&!FRM → capture the next byte, count+1.
  - After byte 0 (count reaches 4) → go to PAR.
- PAR:
  - STB&!FRM → compare the parity byte to the running XOR.
    - Match → push the word, go to IDLE.
    - Mismatch → pulse PAR_ERR, discard the word, go to IDLE.
- STB&FRM in DATA or PAR: pulse FRM_ERR, abandon the partial word, treat the byte as a new byte 3, go to DATA with count=1.

Latency:
- A word is written on the edge that samples a good parity byte.
- OUT_VALID=1 and OUT_DATA are valid from the cycle after that edge.

FIFO rules:
- Show-ahead: OUT_DATA is always the head word.
- Pop occurs on an edge with OUT_READ&OUT_VALID. OUT_READ while empty is ignored.
- A push while full succeeds only if a pop occurs on the same edge.
- Otherwise the word is dropped, OVF is set, and ERR_CNT is incremented.
- Simultaneous push and pop while empty: the push is written, and the pop is ignored because OUT_VALID was 0.

Flow control:
- LINK_BUSY is registered, and equals 1 when free entries ≤ 1 after the current edge.
- The sender must not start a new frame while LINK_BUSY=1. It may complete a frame already in progress.

Error counter:
- ERR_CNT increments by 1 per error event and saturates at 2^ERRW−1.
- At most one error event occurs per cycle by construction.
- ERR_CLR has priority over an increment on the same edge. After the edge, ERR_CNT=0 and OVF=0.

Reset mid-frame: the partial word and all FIFO contents are lost. No error is reported.

Optional Feature:
Macro CONN_LINK_PARITY_EN.
- Defined: frames are 5 bytes with parity checked as above, PAR state present, PAR_ERR active.
- Undefined: frames are 4 data bytes with no parity byte. The word is pushed on the edge sampling byte 0, the PAR state does not exist, and PAR_ERR is tied to 0. All other behaviour is unchanged.

Test Plan (parity enabled unless noted):
1. Frame 0xDE,0xAD,0xBE,0xEF, parity 0x22, contiguous STB → OUT_VALID=1 one cycle after the parity edge, OUT_DATA=0xDEADBEEF, ERR_CNT=0.
2. Same frame with parity byte 0x23 → PAR_ERR pulses 1 cycle, no push, ERR_CNT=1.
3. FRM reasserted after 2 bytes, then a full good frame 0x01,0x02,0x03,0x04, parity 0x04 → FRM_ERR pulses once, OUT_DATA=0x01020304, ERR_CNT=1.
4. Send 4 good frames with OUT_READ=0 (DEPTH=4) → LINK_BUSY=1 after the 3rd push. A 5th frame is dropped: OVF=1, ERR_CNT=1. Pop once and push on the same edge with the FIFO full → no drop.
5. Hold an error source to force 300 errors with ERRW=8 → ERR_CNT saturates at 255. Pulse ERR_CLR together with an error → ERR_CNT=0, OVF=0.
6. Macro undefined: 4-byte frame 0xCA,0xFE,0xBA,0xBE → pushed on the byte-0 edge, OUT_DATA=0xCAFEBABE, PAR_ERR constant 0. Assert RESET mid-frame → all outputs 0 and the FIFO empty.
